// File: rtl/vend_ctrl.sv
// Vending transaction controller: accumulates coin credit, checks selections against
// prices, hands a product to the dispenser and pays change back one unit per beat.
module vend_ctrl #(
  parameter int CREDIT_W   = 4,
  parameter int PRICE_A    = 3,
  parameter int PRICE_B    = 4,
  parameter int MAX_CREDIT = 9,
  parameter int TIMEOUT    = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_vld,
  input  logic [1:0]          coin_val,
  input  logic                sel_vld,
  input  logic                sel_id,
  input  logic                cancel,
  input  logic                disp_rdy,
  output logic                disp_vld,
  output logic                disp_id,
  input  logic                chg_rdy,
  output logic                chg_vld,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                coin_err,
  output logic                sel_short
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_VEND    = 2'd2;
  localparam logic [1:0] ST_CHANGE  = 2'd3;

  logic [1:0]          state, state_n;
  logic [CREDIT_W-1:0] credit_n;
  logic [3:0]          tmo, tmo_n;
  logic                disp_id_n, coin_err_n, sel_short_n;
  logic                coin_legal, coin_fits, coin_take;
  logic [CREDIT_W:0]   coin_add, coin_sum;
  logic [CREDIT_W-1:0] price;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  always_comb begin
    coin_legal = (coin_val == 2'b01) || (coin_val == 2'b10);
    coin_add   = {{(CREDIT_W-1){1'b0}}, coin_val};
    // One extra bit so an overflowing sum is caught rather than wrapped
    coin_sum   = {1'b0, credit} + coin_add;
    coin_fits  = coin_legal && (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));
    price      = sel_id ? CREDIT_W'(PRICE_B) : CREDIT_W'(PRICE_A);
  end

  always_comb begin
    state_n     = state;
    credit_n    = credit;
    tmo_n       = tmo;
    disp_id_n   = disp_id;
    coin_err_n  = coin_vld;
    sel_short_n = 1'b0;
    coin_take   = 1'b0;
    case (state)
      ST_IDLE: begin
        sel_short_n = sel_vld;
        if (coin_vld && coin_fits) begin
          coin_err_n = 1'b0;
          credit_n   = coin_sum[CREDIT_W-1:0];
          tmo_n      = 4'd0;
          state_n    = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (cancel) begin
          state_n = ST_CHANGE;
        end else if (sel_vld && (credit >= price)) begin
          credit_n  = credit - price;
          disp_id_n = sel_id;
          state_n   = ST_VEND;
        end else begin
          // A short selection still blocks a coinciding coin
          sel_short_n = sel_vld;
          coin_take   = !sel_vld && coin_vld && coin_fits;
          if (coin_take) begin
            coin_err_n = 1'b0;
            credit_n   = coin_sum[CREDIT_W-1:0];
            tmo_n      = 4'd0;
          end else begin
            tmo_n = sat_inc(tmo);
            if (tmo_n == 4'(TIMEOUT)) state_n = ST_CHANGE;
          end
        end
      end
      ST_VEND: begin
        if (disp_vld && disp_rdy) state_n = (credit != '0) ? ST_CHANGE : ST_IDLE;
      end
      ST_CHANGE: begin
        if (chg_vld && chg_rdy) begin
          credit_n = credit - 1'b1;
          if (credit_n == '0) state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they line up with state
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      credit    <= '0;
      tmo       <= 4'd0;
      disp_vld  <= 1'b0;
      disp_id   <= 1'b0;
      chg_vld   <= 1'b0;
      busy      <= 1'b0;
      coin_err  <= 1'b0;
      sel_short <= 1'b0;
    end else begin
      state     <= state_n;
      credit    <= credit_n;
      tmo       <= tmo_n;
      disp_vld  <= (state_n == ST_VEND);
      disp_id   <= disp_id_n;
      chg_vld   <= (state_n == ST_CHANGE) && (credit_n != '0);
      busy      <= (state_n == ST_VEND) || (state_n == ST_CHANGE);
      coin_err  <= coin_err_n;
      sel_short <= sel_short_n;
    end
  end

endmodule

// File: tb/tb_vend_ctrl.sv
// Bench for vend_ctrl: directed vector table, a timeout/reset sequence, and a long
// randomized run against a rule-level reference model.
module tb_vend_ctrl;

  localparam int PA   = 3;
  localparam int PB   = 4;
  localparam int MAXC = 9;
  localparam int TOUT = 15;
  localparam int M_IDLE = 0, M_COLLECT = 1, M_VEND = 2, M_CHANGE = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coin_vld = 1'b0;
  logic [1:0] coin_val = 2'b00;
  logic       sel_vld = 1'b0;
  logic       sel_id = 1'b0;
  logic       cancel = 1'b0;
  logic       disp_rdy = 1'b0;
  logic       chg_rdy = 1'b0;
  logic       disp_vld, disp_id, chg_vld, busy, coin_err, sel_short;
  logic [3:0] credit;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vend_ctrl dut (
    .clk(clk), .rst(rst), .coin_vld(coin_vld), .coin_val(coin_val),
    .sel_vld(sel_vld), .sel_id(sel_id), .cancel(cancel), .disp_rdy(disp_rdy),
    .disp_vld(disp_vld), .disp_id(disp_id), .chg_rdy(chg_rdy), .chg_vld(chg_vld),
    .credit(credit), .busy(busy), .coin_err(coin_err), .sel_short(sel_short)
  );

  typedef struct {
    logic       r, cv;
    logic [1:0] cval;
    logic       sv, sid, can, drdy, crdy;
    logic [3:0] credit;
    logic       dv, did, chv, bsy, cerr, ss;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic r, cv, input logic [1:0] cval,
                              input logic sv, sid, can, drdy, crdy,
                              input logic [3:0] cr,
                              input logic dv, did, chv, bsy, cerr, ss);
    vec_t v;
    v.r = r; v.cv = cv; v.cval = cval; v.sv = sv; v.sid = sid; v.can = can;
    v.drdy = drdy; v.crdy = crdy; v.credit = cr; v.dv = dv; v.did = did;
    v.chv = chv; v.bsy = bsy; v.cerr = cerr; v.ss = ss;
    return v;
  endfunction

  function automatic logic [9:0] actual();
    return {credit, disp_vld, disp_id, chg_vld, busy, coin_err, sel_short};
  endfunction

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got credit=%0d dv/id/chv/busy/cerr/ss=%b required credit=%0d dv/id/chv/busy/cerr/ss=%b",
               name, act[9:6], act[5:0], exp[9:6], exp[5:0]);
    end
  endtask

  task automatic drive(input logic r, cv, input logic [1:0] cval,
                       input logic sv, sid, can, drdy, crdy);
    @(negedge clk);
    rst = r; coin_vld = cv; coin_val = cval; sel_vld = sv; sel_id = sid;
    cancel = can; disp_rdy = drdy; chg_rdy = crdy;
  endtask

  // Reference model: transaction rules in plain arithmetic
  int m_mode, m_credit, m_id;
  int m_idle_cnt;
  bit e_cerr, e_ss;

  task automatic model_step(input logic r, cv, input logic [1:0] cval,
                            input logic sv, sid, can, drdy, crdy);
    int  val, price;
    bit  legal, took;
    e_cerr = 0; e_ss = 0; took = 0;
    if (r) begin
      m_mode = M_IDLE; m_credit = 0; m_id = 0; m_idle_cnt = 0;
      return;
    end
    legal = (cval == 2'd1) || (cval == 2'd2);
    val   = int'(cval);
    price = sid ? PB : PA;
    case (m_mode)
      M_IDLE: begin
        e_ss = sv;
        if (cv) begin
          if (legal && val <= MAXC) begin
            m_credit = val; m_mode = M_COLLECT; m_idle_cnt = 0;
          end else e_cerr = 1;
        end
      end
      M_COLLECT: begin
        if (can) begin
          m_mode = M_CHANGE; e_cerr = cv;
        end else if (sv && m_credit >= price) begin
          m_credit -= price; m_id = int'(sid); m_mode = M_VEND; e_cerr = cv;
        end else begin
          if (sv) begin
            e_ss = 1; e_cerr = cv;
          end else if (cv) begin
            if (legal && m_credit + val <= MAXC) begin
              m_credit += val; took = 1;
            end else e_cerr = 1;
          end
          if (took) m_idle_cnt = 0;
          else begin
            m_idle_cnt++;
            if (m_idle_cnt >= TOUT) m_mode = M_CHANGE;
          end
        end
      end
      M_VEND: begin
        e_cerr = cv;
        if (drdy) m_mode = (m_credit > 0) ? M_CHANGE : M_IDLE;
      end
      default: begin
        e_cerr = cv;
        if (crdy) begin
          m_credit--;
          if (m_credit == 0) m_mode = M_IDLE;
        end
      end
    endcase
  endtask

  function automatic logic [9:0] expected();
    logic [3:0] cr;
    cr = 4'(m_credit);
    return {cr, m_mode == M_VEND, m_id[0], (m_mode == M_CHANGE) && (m_credit != 0),
            m_mode >= M_VEND, e_cerr, e_ss};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got simulation still running required finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [9:0] ev;
    logic       r, cv, sv, sid, can, drdy, crdy;
    logic [1:0] cval;
    int         got;

    // rst, cv, cval, sv, sid, can, drdy, crdy | credit, dv, did, chv, busy, cerr, ss
    vt.push_back(mk(1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    vt.push_back(mk(0,1,1,0,0,0,0,0, 1,0,0,0,0,0,0));
    vt.push_back(mk(0,1,1,0,0,0,0,0, 2,0,0,0,0,0,0));
    vt.push_back(mk(0,1,1,0,0,0,0,0, 3,0,0,0,0,0,0));
    vt.push_back(mk(0,0,0,1,0,0,1,0, 0,1,0,0,1,0,0));
    vt.push_back(mk(0,0,0,0,0,0,1,0, 0,0,0,0,0,0,0));
    vt.push_back(mk(0,1,2,0,0,0,0,0, 2,0,0,0,0,0,0));
    vt.push_back(mk(0,0,0,1,1,0,0,0, 2,0,0,0,0,0,1));
    vt.push_back(mk(0,1,2,0,0,0,0,0, 4,0,0,0,0,0,0));
    vt.push_back(mk(0,0,0,1,1,0,0,0, 0,1,1,0,1,0,0));
    vt.push_back(mk(0,0,0,0,0,0,1,0, 0,0,1,0,0,0,0));
    vt.push_back(mk(0,1,2,0,0,0,0,0, 2,0,1,0,0,0,0));
    vt.push_back(mk(0,1,2,0,0,0,0,0, 4,0,1,0,0,0,0));
    vt.push_back(mk(0,1,2,0,0,0,0,0, 6,0,1,0,0,0,0));
    vt.push_back(mk(0,1,2,0,0,0,0,0, 8,0,1,0,0,0,0));
    vt.push_back(mk(0,1,1,0,0,0,0,0, 9,0,1,0,0,0,0));
    vt.push_back(mk(0,1,1,0,0,0,0,0, 9,0,1,0,0,1,0));
    vt.push_back(mk(0,1,3,0,0,0,0,0, 9,0,1,0,0,1,0));
    vt.push_back(mk(0,0,0,1,0,0,0,0, 6,1,0,0,1,0,0));
    vt.push_back(mk(0,1,1,0,0,0,0,0, 6,1,0,0,1,1,0));
    vt.push_back(mk(0,0,0,0,0,0,1,0, 6,0,0,1,1,0,0));
    vt.push_back(mk(0,0,0,1,1,1,0,1, 5,0,0,1,1,0,0));
    vt.push_back(mk(1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    vt.push_back(mk(0,1,2,0,0,0,0,0, 2,0,0,0,0,0,0));
    vt.push_back(mk(0,1,1,0,0,0,0,0, 3,0,0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,0,1,0,0, 3,0,0,1,1,0,0));
    vt.push_back(mk(0,0,0,0,0,0,0,1, 2,0,0,1,1,0,0));
    vt.push_back(mk(0,0,0,0,0,0,0,0, 2,0,0,1,1,0,0));
    vt.push_back(mk(0,0,0,0,0,0,0,1, 1,0,0,1,1,0,0));
    vt.push_back(mk(0,0,0,0,0,0,0,0, 1,0,0,1,1,0,0));
    vt.push_back(mk(0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0));
    vt.push_back(mk(0,1,2,0,0,0,0,0, 2,0,0,0,0,0,0));
    vt.push_back(mk(0,1,1,0,0,0,0,0, 3,0,0,0,0,0,0));
    vt.push_back(mk(0,1,1,1,0,0,1,0, 0,1,0,0,1,1,0));
    vt.push_back(mk(0,0,0,0,0,0,1,0, 0,0,0,0,0,0,0));
    vt.push_back(mk(0,1,2,0,0,0,0,0, 2,0,0,0,0,0,0));
    vt.push_back(mk(0,1,2,0,0,0,0,0, 4,0,0,0,0,0,0));
    vt.push_back(mk(0,0,0,1,0,0,0,0, 1,1,0,0,1,0,0));
    for (int k = 0; k < 3; k++) vt.push_back(mk(0,0,0,0,0,0,0,0, 1,1,0,0,1,0,0));
    vt.push_back(mk(0,0,0,0,0,0,1,0, 1,0,0,1,1,0,0));
    vt.push_back(mk(0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0));
    vt.push_back(mk(0,1,0,0,0,0,0,0, 0,0,0,0,0,1,0));
    vt.push_back(mk(0,0,0,1,0,0,0,0, 0,0,0,0,0,0,1));
    vt.push_back(mk(0,0,0,0,0,1,0,0, 0,0,0,0,0,0,0));

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].r, vt[i].cv, vt[i].cval, vt[i].sv, vt[i].sid, vt[i].can,
            vt[i].drdy, vt[i].crdy);
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), actual(),
            {vt[i].credit, vt[i].dv, vt[i].did, vt[i].chv, vt[i].bsy, vt[i].cerr, vt[i].ss});
    end

    // Timeout: one coin, then count idle cycles until the refund starts
    drive(0,1,2'd1,0,0,0,0,0);
    @(posedge clk); #1;
    got = 0;
    for (int n = 1; n <= 30; n++) begin
      drive(0,0,2'd0,0,0,0,0,0);
      @(posedge clk); #1;
      if (chg_vld) begin
        got = n;
        break;
      end
    end
    checks++;
    if (got != TOUT) begin
      errors++;
      $display("FAIL timeout_len: got %0d idle cycles (0 = none within budget) required %0d", got, TOUT);
    end
    check("timeout_change", actual(), {4'd1, 6'b001100});
    drive(0,0,2'd0,0,0,0,0,1);
    @(posedge clk); #1;
    check("timeout_refund", actual(), {4'd0, 6'b000000});

    // Reset in the middle of a refund with credit 2
    drive(0,1,2'd2,0,0,0,0,0);
    drive(0,0,2'd0,0,0,1,0,0);
    @(posedge clk); #1;
    check("pre_reset_change", actual(), {4'd2, 6'b001100});
    drive(1,0,2'd0,0,0,0,0,1);
    @(posedge clk); #1;
    check("reset_mid_change", actual(), {4'd0, 6'b000000});

    // Randomized run against the reference model
    model_step(1,0,2'd0,0,0,0,0,0);
    for (int i = 0; i < 4000; i++) begin
      r    = ($urandom_range(0, 299) == 0) || (i == 0);
      if (i < 2000) begin
        cv  = ($urandom_range(0, 2) == 0);
        sv  = ($urandom_range(0, 7) == 0);
        can = ($urandom_range(0, 15) == 0);
      end else begin
        cv  = ($urandom_range(0, 24) == 0);
        sv  = ($urandom_range(0, 19) == 0);
        can = ($urandom_range(0, 59) == 0);
      end
      cval = 2'($urandom_range(0, 3));
      sid  = 1'($urandom_range(0, 1));
      drdy = 1'($urandom_range(0, 1));
      crdy = 1'($urandom_range(0, 1));
      drive(r, cv, cval, sv, sid, can, drdy, crdy);
      @(posedge clk);
      model_step(r, cv, cval, sv, sid, can, drdy, crdy);
      #1;
      ev = expected();
      check($sformatf("rand%0d", i), actual(), ev);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
